pong_match_controller: RTL and testbench
========================================

Name: pong_match_controller

Overview:
Match-level sequencer for the pong game engine. It runs the match flow: idle/attract, serve delay, serve handshake, rally, point scoring, and game over. It gates ball motion and visibility, and tells the engine when and which way to serve. It sits beside the game engine in the VGA_CLOCK domain; score outputs feed the score renderer.

Parameters:
WIN_SCORE, 11, points needed to win; legal range 1..15.
SERVE_DELAY_FRAMES, 120, FRAME_TICK pulses to wait before each serve; legal range 0..255.

Ports:
VGA_CLOCK  input  1  sole clock; all logic on posedge.
RESET_N  input  1  asynchronous, active-low reset.
FRAME_TICK  input  1  one-cycle pulse per video frame.
START  input  1  player start button, already synchronous level; rising edge detected internally.
PAUSE  input  1  level; freezes ball during rally.
MISS_A  input  1  one-cycle pulse: ball passed paddle A (left); point to B.
MISS_B  input  1  one-cycle pulse: ball passed paddle B (right); point to A.
SERVE_ACK  input  1  engine has recentred the ball and loaded the direction.
SERVE_REQ  output  1  request engine to recentre ball and serve.
SERVE_DIR  output  1  serve direction: 1 = right (toward B), 0 = left.
BALL_RUN  output  1  engine may advance ball position.
BALL_VISIBLE  output  1  engine may draw ball.
SCORE_A  output  4  player A score.
SCORE_B  output  4  player B score.
GAME_OVER  output  1  match finished.
WINNER  output  1  0 = A, 1 = B; valid only while GAME_OVER is high.
STATE  output  3  current state encoding, for debug.

Behaviour:
- All outputs are registered.
- Reset (async, RESET_N low):
  - state IDLE; SCORE_A = SCORE_B = 0.
  - SERVE_REQ, BALL_RUN, BALL_VISIBLE, GAME_OVER, WINNER = 0; SERVE_DIR = 1.
  - Serve counter = 0; START edge register = 0.
  - Reset asserted mid-operation aborts everything immediately; no pending request survives.
- start_rise = START & ~START_q.
- States: IDLE(0), SERVE_WAIT(1), SERVE(2), RALLY(3), POINT(4), GAME_OVER(5). Encodings 6–7 recover to IDLE.
- IDLE:
  - start_rise -> SERVE_WAIT; scores cleared; SERVE_DIR = 1.
  - Counter loaded with SERVE_DELAY_FRAMES.
- SERVE_WAIT:
  - If counter == 0 -> SERVE next cycle.
  - Else decrement on each FRAME_TICK.
  - Total wait is N ticks + 1 clock; N = 0 gives exactly 1 clock.
- SERVE:
  - SERVE_REQ = 1 and held until SERVE_ACK is sampled high.
  - On that cycle -> RALLY; SERVE_REQ is 0 from the next cycle.
  - SERVE_DIR is stable for the whole time SERVE_REQ is high.
  - SERVE_ACK outside SERVE is ignored.
- RALLY:
  - BALL_RUN = ~PAUSE, applied with 1-cycle registered latency.
  - MISS_A alone: SCORE_B += 1; SERVE_DIR = 0 (serve toward A, who lost the point); -> POINT.
  - MISS_B alone: SCORE_A += 1; SERVE_DIR = 1; -> POINT.
  - MISS_A and MISS_B together: no score change, SERVE_DIR unchanged, -> POINT (replay).
  - Misses are counted even while PAUSE is high.
- MISS_A/MISS_B are ignored in every state other than RALLY.
- POINT (exactly one cycle):
  - If SCORE_A == WIN_SCORE -> GAME_OVER with WINNER = 0.
  - Else if SCORE_B == WIN_SCORE -> GAME_OVER with WINNER = 1.
  - Else -> SERVE_WAIT, counter reloaded.
- GAME_OVER:
  - GAME_OVER = 1; scores frozen.
  - start_rise -> SERVE_WAIT; scores cleared; GAME_OVER = 0; SERVE_DIR = 1.
- BALL_VISIBLE = 1 only in SERVE and RALLY.
- BALL_RUN = 0 in every state except RALLY.
- Score saturation: increments never exceed WIN_SCORE. 4-bit arithmetic, no wrap.
- START held continuously does not restart the match; a new rising edge is required.

Decomposition:
- pong_pkg holds:
  - state encodings (3-bit localparams).
  - SCORE_W = 4.
  - DIR_LEFT = 0, DIR_RIGHT = 1.
  - Default WIN_SCORE and SERVE_DELAY_FRAMES.
- One sub-module, pong_serve_timer:
  - 8-bit loadable down-counter with LOAD, TICK and ZERO.
  - Also reused for the engine's post-miss delay.
- FSM, edge detect and score registers stay in the top module.

Test Plan:
(Bench parameters: WIN_SCORE = 3, SERVE_DELAY_FRAMES = 2; FRAME_TICK every 10 clocks.)
1. Reset, then START rising edge -> SERVE_WAIT. After 2 FRAME_TICKs + 1 clock -> SERVE_REQ = 1, SERVE_DIR = 1, BALL_VISIBLE = 1, BALL_RUN = 0.
2. Hold SERVE_ACK low 5 cycles -> SERVE_REQ stays 1. Pulse SERVE_ACK -> next cycle SERVE_REQ = 0, STATE = 3, BALL_RUN = 1. Raise PAUSE -> BALL_RUN = 0 one cycle later.
3. In RALLY pulse MISS_B -> SCORE_A = 1, SERVE_DIR = 1, BALL_VISIBLE = 0. POINT then SERVE_WAIT. MISS pulses during SERVE_WAIT leave scores unchanged.
4. Pulse MISS_A and MISS_B in the same cycle -> scores unchanged, returns to SERVE_WAIT, SERVE_DIR unchanged.
5. Three MISS_A points -> SCORE_B = 3, GAME_OVER = 1, WINNER = 1, BALL_RUN = 0. Hold START high -> no restart. START low then high -> scores 0, SERVE_WAIT.
6. Assert RESET_N low mid-SERVE (SERVE_REQ = 1) -> SERVE_REQ and scores go to 0 immediately without a clock edge; STATE = 0 after release.

Source files
------------

// File: rtl/pong_pkg.sv
// Shared constants, state encodings and helpers for the pong match logic.
package pong_pkg;

  localparam int SCORE_W = 4;
  localparam int TIMER_W = 8;

  localparam logic DIR_LEFT  = 1'b0;
  localparam logic DIR_RIGHT = 1'b1;

  localparam int DEFAULT_WIN_SCORE          = 11;
  localparam int DEFAULT_SERVE_DELAY_FRAMES = 120;

  localparam logic [2:0] ST_IDLE       = 3'd0;
  localparam logic [2:0] ST_SERVE_WAIT = 3'd1;
  localparam logic [2:0] ST_SERVE      = 3'd2;
  localparam logic [2:0] ST_RALLY      = 3'd3;
  localparam logic [2:0] ST_POINT      = 3'd4;
  localparam logic [2:0] ST_GAME_OVER  = 3'd5;

  typedef enum logic [2:0] {
    S_IDLE       = ST_IDLE,
    S_SERVE_WAIT = ST_SERVE_WAIT,
    S_SERVE      = ST_SERVE,
    S_RALLY      = ST_RALLY,
    S_POINT      = ST_POINT,
    S_GAME_OVER  = ST_GAME_OVER
  } state_t;

  // Score increment that stops at the winning score instead of wrapping.
  function automatic logic [SCORE_W-1:0] sat_inc(input logic [SCORE_W-1:0] v,
                                                 input logic [SCORE_W-1:0] lim);
    return (v < lim) ? v + 1'b1 : v;
  endfunction

endpackage

// File: rtl/pong_serve_timer.sv
// Loadable 8-bit frame down-counter; ZERO is high whenever the count is exhausted.
module pong_serve_timer
  import pong_pkg::*;
(
  input  logic               VGA_CLOCK,
  input  logic               RESET_N,
  input  logic               LOAD,
  input  logic [TIMER_W-1:0] LOAD_VALUE,
  input  logic               TICK,
  output logic               ZERO
);

  logic [TIMER_W-1:0] count;

  // LOAD wins over TICK; the count parks at zero rather than wrapping.
  always_ff @(posedge VGA_CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      count <= '0;
    end else if (LOAD) begin
      count <= LOAD_VALUE;
    end else if (TICK && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign ZERO = (count == '0);

endmodule

// File: rtl/pong_match_controller.sv
// Match sequencer: serve delay, serve handshake, rally gating, scoring and game over.
// Handshake: SERVE_REQ rises on entry to SERVE and holds until SERVE_ACK is sampled high.
module pong_match_controller
  import pong_pkg::*;
#(
  parameter int WIN_SCORE          = DEFAULT_WIN_SCORE,
  parameter int SERVE_DELAY_FRAMES = DEFAULT_SERVE_DELAY_FRAMES
) (
  input  logic               VGA_CLOCK,
  input  logic               RESET_N,
  input  logic               FRAME_TICK,
  input  logic               START,
  input  logic               PAUSE,
  input  logic               MISS_A,
  input  logic               MISS_B,
  input  logic               SERVE_ACK,
  output logic               SERVE_REQ,
  output logic               SERVE_DIR,
  output logic               BALL_RUN,
  output logic               BALL_VISIBLE,
  output logic [SCORE_W-1:0] SCORE_A,
  output logic [SCORE_W-1:0] SCORE_B,
  output logic               GAME_OVER,
  output logic               WINNER,
  output logic [2:0]         STATE
);

  localparam logic [SCORE_W-1:0] WIN   = SCORE_W'(WIN_SCORE);
  localparam logic [TIMER_W-1:0] DELAY = TIMER_W'(SERVE_DELAY_FRAMES);

  state_t             state_q, state_d;
  logic               start_q;
  logic               start_rise;
  logic               timer_load;
  logic               timer_tick;
  logic               timer_zero;
  logic [SCORE_W-1:0] score_a_d, score_b_d;
  logic               serve_dir_d;
  logic               winner_d;

  assign start_rise = START & ~start_q;
  assign timer_tick = FRAME_TICK & (state_q == S_SERVE_WAIT);

  pong_serve_timer u_serve_timer (
    .VGA_CLOCK  (VGA_CLOCK),
    .RESET_N    (RESET_N),
    .LOAD       (timer_load),
    .LOAD_VALUE (DELAY),
    .TICK       (timer_tick),
    .ZERO       (timer_zero)
  );

  always_comb begin
    state_d     = state_q;
    score_a_d   = SCORE_A;
    score_b_d   = SCORE_B;
    serve_dir_d = SERVE_DIR;
    winner_d    = WINNER;
    timer_load  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start_rise) begin
          state_d     = S_SERVE_WAIT;
          score_a_d   = '0;
          score_b_d   = '0;
          serve_dir_d = DIR_RIGHT;
          timer_load  = 1'b1;
        end
      end
      S_SERVE_WAIT: begin
        if (timer_zero) state_d = S_SERVE;
      end
      S_SERVE: begin
        if (SERVE_ACK) state_d = S_RALLY;
      end
      S_RALLY: begin
        // Simultaneous misses replay the point with no score or direction change.
        if (MISS_A && MISS_B) begin
          state_d = S_POINT;
        end else if (MISS_A) begin
          state_d     = S_POINT;
          score_b_d   = sat_inc(SCORE_B, WIN);
          serve_dir_d = DIR_LEFT;
        end else if (MISS_B) begin
          state_d     = S_POINT;
          score_a_d   = sat_inc(SCORE_A, WIN);
          serve_dir_d = DIR_RIGHT;
        end
      end
      S_POINT: begin
        if (SCORE_A == WIN) begin
          state_d  = S_GAME_OVER;
          winner_d = 1'b0;
        end else if (SCORE_B == WIN) begin
          state_d  = S_GAME_OVER;
          winner_d = 1'b1;
        end else begin
          state_d    = S_SERVE_WAIT;
          timer_load = 1'b1;
        end
      end
      S_GAME_OVER: begin
        if (start_rise) begin
          state_d     = S_SERVE_WAIT;
          score_a_d   = '0;
          score_b_d   = '0;
          serve_dir_d = DIR_RIGHT;
          winner_d    = 1'b0;
          timer_load  = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs are registered from the next-state decode so they line up with STATE.
  always_ff @(posedge VGA_CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q      <= S_IDLE;
      start_q      <= 1'b0;
      SCORE_A      <= '0;
      SCORE_B      <= '0;
      SERVE_DIR    <= DIR_RIGHT;
      WINNER       <= 1'b0;
      SERVE_REQ    <= 1'b0;
      BALL_RUN     <= 1'b0;
      BALL_VISIBLE <= 1'b0;
      GAME_OVER    <= 1'b0;
    end else begin
      state_q      <= state_d;
      start_q      <= START;
      SCORE_A      <= score_a_d;
      SCORE_B      <= score_b_d;
      SERVE_DIR    <= serve_dir_d;
      WINNER       <= winner_d;
      SERVE_REQ    <= (state_d == S_SERVE);
      BALL_RUN     <= (state_d == S_RALLY) & ~PAUSE;
      BALL_VISIBLE <= (state_d == S_SERVE) || (state_d == S_RALLY);
      GAME_OVER    <= (state_d == S_GAME_OVER);
    end
  end

  assign STATE = state_q;

endmodule

// File: tb/tb_pong_match_controller.sv
// Bench for pong_match_controller with WIN_SCORE=3, SERVE_DELAY_FRAMES=2, FRAME_TICK every 10 clocks.
module tb_pong_match_controller;

  localparam int WIN = 3;
  localparam int DLY = 2;

  logic       VGA_CLOCK = 1'b0;
  logic       RESET_N = 1'b0;
  logic       FRAME_TICK = 1'b0;
  logic       START = 1'b0;
  logic       PAUSE = 1'b0;
  logic       MISS_A = 1'b0;
  logic       MISS_B = 1'b0;
  logic       SERVE_ACK = 1'b0;
  logic       SERVE_REQ, SERVE_DIR, BALL_RUN, BALL_VISIBLE, GAME_OVER, WINNER;
  logic [3:0] SCORE_A, SCORE_B;
  logic [2:0] STATE;

  pong_match_controller #(.WIN_SCORE(WIN), .SERVE_DELAY_FRAMES(DLY)) dut (
    .VGA_CLOCK    (VGA_CLOCK),
    .RESET_N      (RESET_N),
    .FRAME_TICK   (FRAME_TICK),
    .START        (START),
    .PAUSE        (PAUSE),
    .MISS_A       (MISS_A),
    .MISS_B       (MISS_B),
    .SERVE_ACK    (SERVE_ACK),
    .SERVE_REQ    (SERVE_REQ),
    .SERVE_DIR    (SERVE_DIR),
    .BALL_RUN     (BALL_RUN),
    .BALL_VISIBLE (BALL_VISIBLE),
    .SCORE_A      (SCORE_A),
    .SCORE_B      (SCORE_B),
    .GAME_OVER    (GAME_OVER),
    .WINNER       (WINNER),
    .STATE        (STATE)
  );

  // ---------------- clock / reset ----------------
  always #5 VGA_CLOCK = ~VGA_CLOCK;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // ---------------- scoreboard ----------------
  int         total = 0;
  int         bad = 0;
  int         cyc = 0;
  logic [16:0] exp_q[$];
  logic [16:0] act;
  logic [3:0]  m_a, m_b;
  logic        m_dir;

  assign act = {SERVE_REQ, SERVE_DIR, BALL_RUN, BALL_VISIBLE, SCORE_A, SCORE_B,
                GAME_OVER, WINNER, STATE};

  // Layout: req dir run vis a[4] b[4] go win st[3]
  function automatic logic [16:0] pk(input logic req, input logic dir, input logic run,
                                     input logic vis, input logic [3:0] a, input logic [3:0] b,
                                     input logic go, input logic w, input logic [2:0] st);
    return {req, dir, run, vis, a, b, go, w, st};
  endfunction

  task automatic check(input string name, input logic [16:0] got, input logic [16:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got req/dir/run/vis/a/b/go/w/st=%b want %b", name, got, want);
    end
  endtask

  task automatic check_int(input string name, input int got, input int want);
    total++;
    if (got != want) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, got, want);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick_clk();
    FRAME_TICK = (cyc % 10 == 9);
    @(posedge VGA_CLOCK);
    #1;
    cyc++;
  endtask

  task automatic step_check(input string name, input logic [16:0] want);
    exp_q.push_back(want);
    tick_clk();
    check(name, act, exp_q.pop_front());
  endtask

  task automatic wait_state(input logic [2:0] target, input string name);
    int n = 0;
    while (STATE !== target && n < 200) begin
      tick_clk();
      n++;
    end
    total++;
    if (STATE !== target) begin
      bad++;
      $display("FAIL %s: timeout, state %0d want %0d", name, STATE, target);
    end
  endtask

  task automatic to_rally(input string name);
    wait_state(3'd2, {name, "_wait"});
    SERVE_ACK = 1'b1;
    step_check({name, "_ack"}, pk(0, m_dir, 1, 1, m_a, m_b, 0, 0, 3'd3));
    SERVE_ACK = 1'b0;
  endtask

  task automatic point(input string name, input logic ma, input logic mb);
    if (!(ma && mb)) begin
      if (ma) begin
        m_b   = (m_b < 4'(WIN)) ? m_b + 4'd1 : m_b;
        m_dir = 1'b0;
      end else if (mb) begin
        m_a   = (m_a < 4'(WIN)) ? m_a + 4'd1 : m_a;
        m_dir = 1'b1;
      end
    end
    MISS_A = ma;
    MISS_B = mb;
    step_check({name, "_miss"}, pk(0, m_dir, 0, 0, m_a, m_b, 0, 0, 3'd4));
    MISS_A = 1'b0;
    MISS_B = 1'b0;
    if (m_a == 4'(WIN) || m_b == 4'(WIN))
      step_check({name, "_over"}, pk(0, m_dir, 0, 0, m_a, m_b, 1, (m_a != 4'(WIN)), 3'd5));
    else
      step_check({name, "_next"}, pk(0, m_dir, 0, 0, m_a, m_b, 0, 0, 3'd1));
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    string       name;
    logic        pause;
    logic        miss_a;
    logic        miss_b;
    logic        ack;
    logic [16:0] want;
  } vec_t;

  vec_t tbl[13];

  initial begin
    int ticks;
    int last_t;
    int n;
    logic [2:0] sb;

    tbl[0]  = '{"ack_low0",  0, 0, 0, 0, pk(1, 1, 0, 1, 0, 0, 0, 0, 3'd2)};
    tbl[1]  = '{"ack_low1",  0, 0, 0, 0, pk(1, 1, 0, 1, 0, 0, 0, 0, 3'd2)};
    tbl[2]  = '{"ack_low2",  0, 0, 0, 0, pk(1, 1, 0, 1, 0, 0, 0, 0, 3'd2)};
    tbl[3]  = '{"ack_low3",  0, 0, 0, 0, pk(1, 1, 0, 1, 0, 0, 0, 0, 3'd2)};
    tbl[4]  = '{"ack_low4",  0, 0, 0, 0, pk(1, 1, 0, 1, 0, 0, 0, 0, 3'd2)};
    tbl[5]  = '{"ack",       0, 0, 0, 1, pk(0, 1, 1, 1, 0, 0, 0, 0, 3'd3)};
    tbl[6]  = '{"rally_run", 0, 0, 0, 0, pk(0, 1, 1, 1, 0, 0, 0, 0, 3'd3)};
    tbl[7]  = '{"pause",     1, 0, 0, 0, pk(0, 1, 0, 1, 0, 0, 0, 0, 3'd3)};
    tbl[8]  = '{"miss_b_pz", 1, 0, 1, 0, pk(0, 1, 0, 0, 1, 0, 0, 0, 3'd4)};
    tbl[9]  = '{"point",     0, 0, 0, 0, pk(0, 1, 0, 0, 1, 0, 0, 0, 3'd1)};
    tbl[10] = '{"sw_miss_a", 0, 1, 0, 0, pk(0, 1, 0, 0, 1, 0, 0, 0, 3'd1)};
    tbl[11] = '{"sw_miss_b", 0, 0, 1, 0, pk(0, 1, 0, 0, 1, 0, 0, 0, 3'd1)};
    tbl[12] = '{"sw_ack",    0, 0, 0, 1, pk(0, 1, 0, 0, 1, 0, 0, 0, 3'd1)};

    // Reset state
    repeat (3) tick_clk();
    check("reset", act, pk(0, 1, 0, 0, 0, 0, 0, 0, 3'd0));
    RESET_N = 1'b1;
    step_check("idle", pk(0, 1, 0, 0, 0, 0, 0, 0, 3'd0));

    // Start and serve delay: 2 frame ticks then exactly one more clock
    START = 1'b1;
    step_check("start", pk(0, 1, 0, 0, 0, 0, 0, 0, 3'd1));
    ticks  = 0;
    last_t = -100;
    n      = 0;
    while (STATE !== 3'd2 && n < 100) begin
      sb = STATE;
      tick_clk();
      n++;
      if (FRAME_TICK && sb == 3'd1) begin
        ticks++;
        last_t = n;
      end
    end
    check_int("wait_ticks", ticks, DLY);
    check_int("wait_tail", n - last_t, 1);
    check("serve_entry", act, pk(1, 1, 0, 1, 0, 0, 0, 0, 3'd2));

    // Serve handshake, rally, pause, scoring, ignored misses
    foreach (tbl[i]) begin
      PAUSE     = tbl[i].pause;
      MISS_A    = tbl[i].miss_a;
      MISS_B    = tbl[i].miss_b;
      SERVE_ACK = tbl[i].ack;
      step_check(tbl[i].name, tbl[i].want);
    end
    PAUSE = 1'b0; MISS_A = 1'b0; MISS_B = 1'b0; SERVE_ACK = 1'b0;
    m_a = 4'd1; m_b = 4'd0; m_dir = 1'b1;

    // Replays and run to game over with B winning
    to_rally("r1"); point("both1", 1, 1);
    to_rally("r2"); point("pa1", 1, 0);
    to_rally("r3"); point("both2", 1, 1);
    to_rally("r4"); point("pa2", 1, 0);
    to_rally("r5"); point("pa3", 1, 0);

    // START still held high since the first start: no restart
    MISS_A = 1'b1;
    step_check("go_hold0", pk(0, 0, 0, 0, 1, 3, 1, 1, 3'd5));
    MISS_A = 1'b0;
    for (int k = 0; k < 4; k++) step_check("go_hold", pk(0, 0, 0, 0, 1, 3, 1, 1, 3'd5));
    START = 1'b0;
    step_check("go_start_low", pk(0, 0, 0, 0, 1, 3, 1, 1, 3'd5));
    START = 1'b1;
    step_check("restart", pk(0, 1, 0, 0, 0, 0, 0, 0, 3'd1));
    m_a = 4'd0; m_b = 4'd0; m_dir = 1'b1;

    // Async reset during an outstanding serve request
    to_rally("r6"); point("pb1", 0, 1);
    wait_state(3'd2, "serve_pre_reset_wait");
    check("serve_pre_reset", act, pk(1, 1, 0, 1, 1, 0, 0, 0, 3'd2));
    #2;
    RESET_N = 1'b0;
    #1;
    check("async_reset", act, pk(0, 1, 0, 0, 0, 0, 0, 0, 3'd0));
    START = 1'b0;
    tick_clk();
    tick_clk();
    RESET_N = 1'b1;
    step_check("post_reset0", pk(0, 1, 0, 0, 0, 0, 0, 0, 3'd0));
    step_check("post_reset1", pk(0, 1, 0, 0, 0, 0, 0, 0, 3'd0));

    // ---------------- report ----------------
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
